// File: rtl/ucie_fdi_tx_vc_arbiter.sv
// FDI transmit-side flit scheduler: round-robin VC arbitration with per-VC link
// credits and a one-deep replay register that re-sends a cancelled flit.
module ucie_fdi_tx_vc_arbiter #(
  parameter int FLIT_WIDTH    = 256,
  parameter int NUM_VCS       = 8,
  parameter int CREDIT_WIDTH  = 8,
  parameter int INIT_CREDITS  = 16,
  parameter int ENABLE_CANCEL = 1,
  parameter int VC_W          = $clog2(NUM_VCS)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_VCS-1:0]            vc_req_valid,
  input  logic [NUM_VCS*FLIT_WIDTH-1:0] vc_req_data,
  output logic [NUM_VCS-1:0]            vc_req_ready,
  output logic                          pl_flit_valid,
  output logic [FLIT_WIDTH-1:0]         pl_flit_data,
  output logic [VC_W-1:0]               pl_flit_vc,
  input  logic                          lp_flit_ready,
  input  logic                          flit_cancel,
  input  logic [NUM_VCS-1:0]            lp_credit_return,
  output logic [NUM_VCS-1:0]            vc_credit_zero,
  output logic                          credit_overflow_err,
  output logic                          cancel_err
);

  localparam logic [CREDIT_WIDTH-1:0] CRED_MAX  = '1;
  localparam logic [CREDIT_WIDTH-1:0] CRED_INIT = CREDIT_WIDTH'(INIT_CREDITS);

  logic                    r_valid;
  logic [FLIT_WIDTH-1:0]   r_data;
  logic [VC_W-1:0]         r_vc;
  logic [FLIT_WIDTH-1:0]   r_rr_data;
  logic [VC_W-1:0]         r_rr_vc;
  logic                    r_replay;
  logic                    r_hs_prev;
  logic                    r_ovf;
  logic                    r_cerr;
  logic [VC_W-1:0]         r_ptr;
  logic [CREDIT_WIDTH-1:0] r_credit [NUM_VCS];

  logic                    w_cancel_req;
  logic                    w_cancel_eff;
  logic                    w_hs;
  logic                    w_free;
  logic                    w_any;
  logic                    w_load;
  logic [VC_W-1:0]         w_grant;
  logic [FLIT_WIDTH-1:0]   w_sel_data;
  logic [NUM_VCS-1:0]      w_elig;
  logic [NUM_VCS-1:0]      w_rdy;

  // The replay register overrides the output register while a replay is owed.
  assign pl_flit_valid = r_valid | r_replay;
  assign pl_flit_data  = r_replay ? r_rr_data : r_data;
  assign pl_flit_vc    = r_replay ? r_rr_vc   : r_vc;

  assign w_cancel_req  = (ENABLE_CANCEL != 0) && flit_cancel;
  assign w_cancel_eff  = w_cancel_req && r_hs_prev;
  assign w_hs          = pl_flit_valid && lp_flit_ready && !w_cancel_eff;
  assign w_free        = !r_replay && (!r_valid || w_hs);
  assign w_load        = w_free && w_any;

  assign credit_overflow_err = r_ovf;
  assign cancel_err          = r_cerr;

  always_comb begin
    int idx;
    idx        = 0;
    w_any      = 1'b0;
    w_grant    = '0;
    w_sel_data = '0;
    for (int v = 0; v < NUM_VCS; v++) begin
      w_elig[v] = vc_req_valid[v] && (r_credit[v] != '0);
    end
    // Search starts one past the last winner so the last winner ranks lowest.
    for (int off = 1; off <= NUM_VCS; off++) begin
      idx = (int'(r_ptr) + off) % NUM_VCS;
      if (!w_any && w_elig[idx]) begin
        w_any      = 1'b1;
        w_grant    = VC_W'(idx);
        w_sel_data = vc_req_data[idx*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) begin
      w_rdy[v]          = resetn && w_load && (w_grant == VC_W'(v));
      vc_credit_zero[v] = (r_credit[v] == '0);
    end
  end

  assign vc_req_ready = w_rdy;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_vc      <= '0;
      r_replay  <= 1'b0;
      r_hs_prev <= 1'b0;
      r_ovf     <= 1'b0;
      r_cerr    <= 1'b0;
      r_ptr     <= '0;
      for (int v = 0; v < NUM_VCS; v++) r_credit[v] <= CRED_INIT;
    end else begin
      r_hs_prev <= w_hs;
      if (w_free) begin
        r_valid <= w_any;
        if (w_any) begin
          r_data <= w_sel_data;
          r_vc   <= w_grant;
          r_ptr  <= w_grant;
        end
      end
      if (w_cancel_eff)          r_replay <= 1'b1;
      else if (w_hs && r_replay) r_replay <= 1'b0;
      if (w_cancel_req && !r_hs_prev) r_cerr <= 1'b1;
      // Credits are only spent on an output-register load, never on replay.
      for (int v = 0; v < NUM_VCS; v++) begin
        if (lp_credit_return[v] && !w_rdy[v]) begin
          if (r_credit[v] == CRED_MAX) r_ovf <= 1'b1;
          else                         r_credit[v] <= r_credit[v] + 1'b1;
        end else if (w_rdy[v] && !lp_credit_return[v]) begin
          r_credit[v] <= r_credit[v] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_rr_data <= pl_flit_data;
      r_rr_vc   <= pl_flit_vc;
    end
  end

endmodule
